// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT operand fetch block.
package ntt_pkg;

  localparam int NUM_LAYERS      = 7;
  localparam int BEATS_PER_LAYER = 4;
  localparam int NUM_ROWS        = 8;
  localparam int NUM_BEATS       = NUM_LAYERS * BEATS_PER_LAYER;
  localparam logic [4:0] LAST_BEAT = 5'(NUM_BEATS - 1);

  typedef logic [15:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } row_pair_t;

  typedef struct packed {
    logic       last;
    logic [2:0] layer;
    logic       permute;
    logic       intt;
  } fetch_side_t;

  // Row pair for beat k of layer L; the partner row sits one stride (len/32) above.
  function automatic row_pair_t beat_rows(input logic [2:0] layer, input logic [1:0] k);
    row_pair_t r;
    case (layer)
      3'd0: begin
        r.a = {1'b0, k};
        r.b = r.a + 3'd4;
      end
      3'd1: begin
        r.a = {k[1], 1'b0, k[0]};
        r.b = r.a + 3'd2;
      end
      default: begin
        r.a = {k, 1'b0};
        r.b = r.a + 3'd1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ntt_fetch_fifo.sv
// Two-entry output FIFO; the head is read straight from storage so it holds while stalled.
module ntt_fetch_fifo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  // Pointer/occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    do_pop  = i_pop & (count_q != 2'd0);
    do_push = i_push & ((count_q != 2'd2) | do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_valid = (count_q != 2'd0);
  assign o_count = count_q;

endmodule

// File: rtl/ntt_operand_fetch.sv
// Sequences 7x4 row-pair reads per NTT/INTT pass and streams them through a 2-deep FIFO.
// Define NTT_FETCH_STALL_CNT_EN to add the o_stall_cnt back-pressure counter.
module ntt_operand_fetch
  import ntt_pkg::*;
#(
  parameter int HALF_NUM_BFU = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_intt,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_rd_en,
  output logic [2:0]                    o_rd_addr_a,
  output logic [2:0]                    o_rd_addr_b,
  input  coef_t [2*HALF_NUM_BFU-1:0]    i_rd_data_a,
  input  coef_t [2*HALF_NUM_BFU-1:0]    i_rd_data_b,
  output coef_t [2*HALF_NUM_BFU-1:0]    o_a,
  output coef_t [2*HALF_NUM_BFU-1:0]    o_b,
  output logic                          o_intt,
  output logic                          o_permute,
  output logic [2:0]                    o_layer,
  output logic                          o_valid,
`ifdef NTT_FETCH_STALL_CNT_EN
  output logic [15:0]                   o_stall_cnt,
`endif
  input  logic                          i_ready
);

  localparam int DATA_W = 2 * HALF_NUM_BFU * 16;
  localparam int SIDE_W = $bits(fetch_side_t);
  localparam int PAY_W  = 2 * DATA_W + SIDE_W;

  fetch_state_e state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         intt_q, intt_d;
  logic         inflight_q, inflight_d;
  fetch_side_t  side_q, side_d;

  logic         issue_s, start_s, pop_s, can_issue_s, mode_s, done_s;
  logic [2:0]   occ_s, layer_idx_s, layer_s;
  row_pair_t    rows_s;
  fetch_side_t  head_side_s;
  logic [PAY_W-1:0] head_s;
  logic         fifo_valid_s;
  logic [1:0]   fifo_count_s;

  // Pass FSM plus read issue; the first read goes out in the i_start cycle itself.
  always_comb begin
    pop_s       = fifo_valid_s & i_ready & ~i_rst;
    occ_s       = {1'b0, fifo_count_s} + {2'b00, inflight_q};
    can_issue_s = (occ_s < 3'd2) | pop_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    intt_d      = intt_q;
    issue_s     = 1'b0;
    start_s     = 1'b0;
    done_s      = 1'b0;
    mode_s      = intt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          start_s = 1'b1;
          mode_s  = i_intt;
          intt_d  = i_intt;
          issue_s = 1'b1;
          cnt_d   = 5'd1;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = 5'd0;
        end
      end
      ST_ISSUE: begin
        if (can_issue_s) begin
          issue_s = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = 5'd0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DRAIN: begin
        if (pop_s & head_side_s.last) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    layer_idx_s    = cnt_q[4:2];
    layer_s        = mode_s ? (3'd6 - layer_idx_s) : layer_idx_s;
    rows_s         = beat_rows(layer_s, cnt_q[1:0]);
    side_d.last    = (cnt_q == LAST_BEAT);
    side_d.layer   = layer_s;
    side_d.permute = (layer_s >= 3'd3) & ~mode_s;
    side_d.intt    = mode_s;
    inflight_d     = issue_s & ~i_rst;
  end

  // State, beat counter, latched mode and the sideband of the read in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      intt_q     <= 1'b0;
      inflight_q <= 1'b0;
      side_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      intt_q     <= intt_d;
      inflight_q <= inflight_d;
      side_q     <= side_d;
    end
  end

  ntt_fetch_fifo #(.W(PAY_W)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (inflight_q),
    .i_push_data ({side_q, i_rd_data_b, i_rd_data_a}),
    .i_pop       (pop_s),
    .o_head      (head_s),
    .o_valid     (fifo_valid_s),
    .o_count     (fifo_count_s)
  );

  assign head_side_s = fetch_side_t'(head_s[PAY_W-1 -: SIDE_W]);
  assign o_a         = head_s[DATA_W-1:0];
  assign o_b         = head_s[2*DATA_W-1:DATA_W];
  assign o_layer     = head_side_s.layer;
  assign o_permute   = head_side_s.permute;
  assign o_intt      = head_side_s.intt;
  assign o_valid     = fifo_valid_s & ~i_rst;
  assign o_done      = done_s;
  assign o_busy      = (state_q != ST_IDLE) & ~i_rst;
  assign o_rd_en     = issue_s & ~i_rst;
  assign o_rd_addr_a = o_rd_en ? rows_s.a : 3'd0;
  assign o_rd_addr_b = o_rd_en ? rows_s.b : 3'd0;

`ifdef NTT_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles, restarted by each accepted pass.
  always_comb begin
    if (start_s) begin
      stall_cnt_d = 16'd0;
    end else if (o_valid & ~i_ready & (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_operand_fetch.sv
// Scoreboard bench for ntt_operand_fetch: reference beat list built from the layer/row rules.
module tb_ntt_operand_fetch;

  localparam int HALF = 16;
  localparam int DW   = 2 * HALF * 16;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    layer;
    logic          permute;
    logic          intt;
  } beat_t;

  logic clk = 1'b0;
  logic rst, start, intt, ready;
  logic busy, done, rd_en, valid, o_intt, o_permute;
  logic [2:0] addr_a, addr_b, o_layer;
  logic [DW-1:0] rd_data_a, rd_data_b, oa, ob;
`ifdef NTT_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ntt_operand_fetch #(.HALF_NUM_BFU(HALF)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_intt(intt),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en),
    .o_rd_addr_a(addr_a), .o_rd_addr_b(addr_b),
    .i_rd_data_a(rd_data_a), .i_rd_data_b(rd_data_b),
    .o_a(oa), .o_b(ob), .o_intt(o_intt), .o_permute(o_permute),
    .o_layer(o_layer), .o_valid(valid),
`ifdef NTT_FETCH_STALL_CNT_EN
    .o_stall_cnt(stall_cnt),
`endif
    .i_ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] bank_a [8];
  logic [DW-1:0] bank_b [8];

  // Coefficient bank: one-cycle read latency.
  always @(posedge clk) begin
    rd_data_a <= rd_en ? bank_a[addr_a] : '0;
    rd_data_b <= rd_en ? bank_b[addr_b] : '0;
  end

  int n_vec = 0, n_err = 0;
  beat_t exp_q[$];
  logic [5:0] addr_log[$];
  bit pass_active = 1'b0, saw_valid = 1'b0, prev_stall = 1'b0;
  int issued = 0, accepted = 0, stall_model = 0, stall_left = 0, ready_mode = 0;
  int start_cyc = 0, first_valid_cyc = -1, done_cyc = -1;
  logic [DW-1:0] hold_a, hold_b;
  logic [4:0] hold_side;
  beat_t mon_e;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (low 64 bits) at cycle %0d", nm, act[63:0], exp[63:0], cyc);
    end
  endtask

  // Reference beat list: len = 128 >> L, stride s = len/32 for wide layers.
  task automatic build_expected(input bit m);
    int L, len, s, cnt, ra, rb;
    beat_t e;
    for (int j = 0; j < 7; j++) begin
      L   = m ? 6 - j : j;
      len = 128 >> L;
      for (int k = 0; k < 4; k++) begin
        if (len >= 32) begin
          s = len / 32;
          cnt = 0;
          ra = 0;
          for (int r = 0; r < 8; r++) begin
            if ((r & s) == 0) begin
              if (cnt == k) ra = r;
              cnt++;
            end
          end
          rb = ra + s;
        end else begin
          ra = 2 * k;
          rb = 2 * k + 1;
        end
        e.a = bank_a[ra];
        e.b = bank_b[rb];
        e.layer = 3'(L);
        e.permute = (L >= 3) && !m;
        e.intt = m;
        exp_q.push_back(e);
      end
    end
  endtask

  // Ready pattern generator, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = ~ready;
        2: ready = 1'($urandom_range(0, 1));
        3: begin
          if (saw_valid && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
          end else begin
            ready = 1'b1;
          end
        end
        default: ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        issued++;
        addr_log.push_back({addr_a, addr_b});
      end
      if (valid && !saw_valid) begin
        saw_valid = 1'b1;
        first_valid_cyc = cyc;
      end
      if (valid && !ready) stall_model++;
      if (prev_stall) begin
        chk("hold_valid", valid, 1'b1);
        chk("hold_a", oa, hold_a);
        chk("hold_b", ob, hold_b);
        chk("hold_side", {o_layer, o_permute, o_intt}, hold_side);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got a beat with layer %0d, required none at cycle %0d", o_layer, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          accepted++;
          chk("beat_a", oa, mon_e.a);
          chk("beat_b", ob, mon_e.b);
          chk("beat_layer", o_layer, mon_e.layer);
          chk("beat_permute", o_permute, mon_e.permute);
          chk("beat_intt", o_intt, mon_e.intt);
          chk("done_flag", done, exp_q.size() == 0);
          if (exp_q.size() == 0) begin
            done_cyc = cyc;
            pass_active = 1'b0;
`ifdef NTT_FETCH_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stall_model);
`endif
          end
        end
      end else if (done) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got o_done=1, required 0 at cycle %0d", cyc);
      end
      if (rd_en) chk("outstanding_le2", (issued - accepted) <= 2, 1'b1);
      prev_stall = valid && !ready;
      hold_a = oa;
      hold_b = ob;
      hold_side = {o_layer, o_permute, o_intt};
    end
  end

  task automatic fill_bank();
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < DW / 32; w++) begin
        bank_a[r][w*32 +: 32] = $urandom;
        bank_b[r][w*32 +: 32] = $urandom;
      end
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_valid"}, valid, 1'b0);
    chk({nm, "_rd_en"}, rd_en, 1'b0);
    chk({nm, "_permute"}, o_permute, 1'b0);
    chk({nm, "_intt"}, o_intt, 1'b0);
    chk({nm, "_layer"}, o_layer, 3'd0);
    chk({nm, "_addr"}, {addr_a, addr_b}, 6'd0);
    chk({nm, "_a"}, oa, '0);
  endtask

  task automatic begin_pass(input bit m, input int rmode);
    @(posedge clk);
    #1;
    fill_bank();
    exp_q.delete();
    build_expected(m);
    addr_log.delete();
    issued = 0;
    accepted = 0;
    stall_model = 0;
    saw_valid = 1'b0;
    first_valid_cyc = -1;
    done_cyc = -1;
    stall_left = 10;
    ready_mode = rmode;
    pass_active = 1'b1;
    start_cyc = cyc;
    start = 1'b1;
    intt = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    intt = 1'($urandom);
  endtask

  task automatic run_pass(input bit m, input int rmode, input bit extra);
    int i;
    begin_pass(m, rmode);
    for (i = 0; i < 600; i++) begin
      if (!pass_active && !busy) break;
      start = extra && (i == 5);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (i == 600) begin
      n_vec++;
      n_err++;
      $display("FAIL pass_timeout: got %0d beats, required 28", accepted);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    int i;
    rst = 1'b1;
    start = 1'b0;
    intt = 1'b0;
    ready = 1'b1;
    fill_bank();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    run_pass(1'b0, 0, 1'b0);
    chk("first_valid_lat", first_valid_cyc - start_cyc, 2);
    chk("done_lat", done_cyc - start_cyc, 29);
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ka, kb;
      ka = 3'(k);
      kb = 3'(k + 4);
      chk("ntt_l0_rows", addr_log[k], {ka, kb});
    end

    run_pass(1'b1, 0, 1'b0);
    chk("intt_first_rows", addr_log[0], 6'b000_001);
    chk("intt_last_rows", addr_log[27], 6'b011_111);
    chk("intt_done_lat", done_cyc - start_cyc, 29);

    run_pass(1'b0, 1, 1'b0);
    run_pass(1'b1, 1, 1'b0);
    run_pass(1'b0, 3, 1'b1);

    // Reset after 13 accepted beats aborts the pass.
    begin_pass(1'b0, 0);
    for (i = 0; i < 200; i++) begin
      if (accepted >= 13) break;
      @(posedge clk);
      #1;
    end
    chk("reached_beat13", accepted >= 13, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    pass_active = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    run_pass(1'b0, 0, 1'b0);
    chk("post_reset_done_lat", done_cyc - start_cyc, 29);

    for (int p = 0; p < 4; p++) run_pass(1'($urandom), 2, 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
